operand_fetch: RTL and testbench
================================

// Module: operand_fetch
// PURPOSE
//  Issue stage between decode and execute. Drives the two register-file read ports and bypasses writeback data.
//  Tracks pending destination registers in a scoreboard, stalls on RAW/WAW hazards, and registers operands into execute.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  XLEN    32  datapath width
//  ADR_W   6   register address width, matches register_file ports
//  NB_REGS 32  architectural registers tracked; register 0 is constant zero
//  CTRL_W  16  opaque decoded-control bundle width, passed through unchanged
// PORTS
//  clk            in   1       clock
//  reset_n        in   1       asynchronous active-low reset
//  dec_valid_i    in   1       decode presents instruction
//  dec_ready_o    out  1       stage accepts instruction this cycle
//  dec_rs1_i      in   ADR_W   source 1 index
//  dec_rs1_use_i  in   1       rs1 is read
//  dec_rs2_i      in   ADR_W   source 2 index
//  dec_rs2_use_i  in   1       rs2 is read
//  dec_rd_i       in   ADR_W   destination index
//  dec_rd_use_i   in   1       instruction writes rd
//  dec_imm_i      in   XLEN    immediate
//  dec_ctrl_i     in   CTRL_W  control bundle
//  rf_adr0_o      out  ADR_W   register-file read address 0, = dec_rs1_i, combinational
//  rf_data0_i     in   XLEN    register-file read data 0, same cycle
//  rf_adr1_o      out  ADR_W   register-file read address 1, = dec_rs2_i
//  rf_data1_i     in   XLEN    register-file read data 1
//  wb_valid_i     in   1       writeback this cycle (same signals feed register file write port)
//  wb_adr_i       in   ADR_W   writeback index
//  wb_data_i      in   XLEN    writeback data
//  flush_i        in   1       kill instruction held in the execute register
//  ex_valid_o     out  1       execute register holds an instruction
//  ex_ready_i     in   1       execute consumes
//  ex_rs1_data_o  out  XLEN    operand 1, 0 when rs1 unused or index 0
//  ex_rs2_data_o  out  XLEN    operand 2, same rule
//  ex_rd_o        out  ADR_W   destination
//  ex_rd_use_o    out  1       destination valid
//  ex_imm_o       out  XLEN    immediate
//  ex_ctrl_o      out  CTRL_W  control bundle
// BEHAVIOUR
//  Reset: every ex_* output = 0, scoreboard all clear. dec_ready_o = 1 (combinational, no hazards).
//  Scoreboard: busy[NB_REGS-1:0]; busy[0] is hard-wired 0.
//   - set: accept & dec_rd_use_i & rd!=0
//   - clear: wb_valid_i & wb_adr_i!=0
//  Same-cycle set and clear of one index: set wins.
//  pend(r) = busy[r] & ~(wb_valid_i & wb_adr_i==r).
//  hazard = (rs1_use & pend(rs1)) | (rs2_use & pend(rs2)) | (rd_use & pend(rd)). Last term is WAW.
//  dec_ready_o = ~hazard & ~flush_i & (~ex_valid_o | ex_ready_i). accept = dec_valid_i & dec_ready_o.
//  Bypass: operand = wb_data_i if wb_valid_i & wb_adr_i==rs & rs!=0, else rf_data. rs==0 or unused gives 0.
//  Execute register, on the cycle after accept:
//   - ex_valid_o=1; operands, rd, imm and ctrl captured.
//  Latency: one cycle from accept to ex_valid_o.
//  Hold: ex_valid_o & ~ex_ready_i keeps all ex_* stable; no new accept.
//  Drain: ex_valid_o & ex_ready_i & ~accept gives ex_valid_o=0 next cycle.
//  Back-to-back: ex_ready_i & accept replaces the entry with no bubble.
//  flush_i, takes priority over everything:
//   - next cycle ex_valid_o=0
//   - if ex_valid_o & ex_rd_use_o, busy[ex_rd_o] is cleared
//   - no accept in the flush cycle
//  Writebacks from older instructions still clear busy normally.
//  Reset mid-operation clears scoreboard and execute register asynchronously; a pending writeback is lost.
//  Indices >= NB_REGS never occur; busy decode ignores upper bits.
// STRUCTURE
//  Shared package klaw_pkg: XLEN, ADR_W, NB_REGS, CTRL_W, typedef struct ex_payload_t {rs1,rs2,rd,rd_use,imm,ctrl}.
//  Sub-module scoreboard (set, clear, flush-clear and query ports) holds busy plus priority rules.
//  Top holds the hazard check, bypass muxes and execute register.
// TESTING
//  1. Accept addi rd=5, rs1=0, ex_ready_i=1 -> next cycle ex_valid_o=1, ex_rd_o=5, rs1 data 0; busy[5]=1.
//  2. busy[5]=1, dec rs1=5, no wb -> dec_ready_o=0 for every stall cycle.
//     Then wb_valid_i=1, adr 5, data 0xDEAD_BEEF -> accept same cycle, ex_rs1_data_o=0xDEAD_BEEF.
//  3. ex_valid_o=1, ex_ready_i=0 for 3 cycles -> ex_* unchanged and dec_ready_o=0.
//     Then ex_ready_i=1 with a new valid instruction -> replaced with no bubble.
//  4. Flush with ex_rd_o=7, busy[7]=1 -> next cycle ex_valid_o=0, busy[7]=0; dec_ready_o=0 during flush.
//  5. Instruction with rd=0, then rs1=0 reader -> no stall, operand 0, busy[0] stays 0.
//  6. wb to 9 and accept of rd=9 in the same cycle -> busy[9]=1 afterwards (set wins).
//     Assert reset_n low mid-stall -> all ex_* 0, busy cleared asynchronously.

Source files
------------

// File: rtl/klaw_pkg.sv
// Shared issue-stage definitions: datapath widths and the payload carried
// in the execute register.
package klaw_pkg;

    localparam int XLEN    = 32;
    localparam int ADR_W   = 6;
    localparam int NB_REGS = 32;
    localparam int CTRL_W  = 16;

    typedef struct packed {
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [ADR_W-1:0]  rd;
        logic              rd_use;
        logic [XLEN-1:0]   imm;
        logic [CTRL_W-1:0] ctrl;
    } ex_payload_t;

    // Register index to one-hot; indices beyond NB_REGS never occur.
    function automatic logic [NB_REGS-1:0] adr_onehot(input logic [ADR_W-1:0] adr);
        return NB_REGS'(1) << adr;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register,
// register 0 never busy, set wins over any same-cycle clear.
module operand_fetch_scoreboard
    import klaw_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               set_i,
    input  logic [ADR_W-1:0]   set_adr_i,
    input  logic               clr_i,
    input  logic [ADR_W-1:0]   clr_adr_i,
    input  logic               flush_clr_i,
    input  logic [ADR_W-1:0]   flush_clr_adr_i,
    input  logic [ADR_W-1:0]   q_rs1_adr_i,
    input  logic [ADR_W-1:0]   q_rs2_adr_i,
    input  logic [ADR_W-1:0]   q_rd_adr_i,
    output logic               pend_rs1_o,
    output logic               pend_rs2_o,
    output logic               pend_rd_o,
    output logic [NB_REGS-1:0] busy_o
);

    logic [NB_REGS-1:0] busy_q;
    logic [NB_REGS-1:0] busy_d;
    logic [NB_REGS-1:0] set_vec;
    logic [NB_REGS-1:0] clr_vec;
    logic [NB_REGS-1:0] pend_vec;

    always_comb begin
        set_vec = set_i ? adr_onehot(set_adr_i) : '0;
        clr_vec = '0;
        if (clr_i)       clr_vec = clr_vec | adr_onehot(clr_adr_i);
        if (flush_clr_i) clr_vec = clr_vec | adr_onehot(flush_clr_adr_i);
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
        // A register being written back this cycle is no longer a hazard.
        pend_vec  = busy_q & ~(clr_i ? adr_onehot(clr_adr_i) : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    assign pend_rs1_o = |(pend_vec & adr_onehot(q_rs1_adr_i));
    assign pend_rs2_o = |(pend_vec & adr_onehot(q_rs2_adr_i));
    assign pend_rd_o  = |(pend_vec & adr_onehot(q_rd_adr_i));
    assign busy_o     = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: hazard check against the scoreboard, writeback bypass of
// register-file read data, and the registered hand-off into execute.
module operand_fetch
    import klaw_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [ADR_W-1:0]  dec_rs1_i,
    input  logic              dec_rs1_use_i,
    input  logic [ADR_W-1:0]  dec_rs2_i,
    input  logic              dec_rs2_use_i,
    input  logic [ADR_W-1:0]  dec_rd_i,
    input  logic              dec_rd_use_i,
    input  logic [XLEN-1:0]   dec_imm_i,
    input  logic [CTRL_W-1:0] dec_ctrl_i,
    output logic [ADR_W-1:0]  rf_adr0_o,
    input  logic [XLEN-1:0]   rf_data0_i,
    output logic [ADR_W-1:0]  rf_adr1_o,
    input  logic [XLEN-1:0]   rf_data1_i,
    input  logic              wb_valid_i,
    input  logic [ADR_W-1:0]  wb_adr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    input  logic              flush_i,
    output logic              ex_valid_o,
    input  logic              ex_ready_i,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [ADR_W-1:0]  ex_rd_o,
    output logic              ex_rd_use_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [CTRL_W-1:0] ex_ctrl_o
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and an unaccepted execute entry
    // stays stable until ex_ready_i or flush_i.
    logic        ex_valid_q, ex_valid_d;
    ex_payload_t ex_q, ex_d;
    logic        pend_rs1, pend_rs2, pend_rd;
    logic        hazard;
    logic        accept;
    logic [XLEN-1:0] op1, op2;

    function automatic logic [XLEN-1:0] operand(input logic use_r, input logic [ADR_W-1:0] adr,
                                                 input logic [XLEN-1:0] rf_data);
        if (!use_r || adr == '0)              return '0;
        else if (wb_valid_i && wb_adr_i == adr) return wb_data_i;
        else                                   return rf_data;
    endfunction

    operand_fetch_scoreboard u_scoreboard (
        .clk             (clk),
        .reset_n         (reset_n),
        .set_i           (accept && dec_rd_use_i && dec_rd_i != '0),
        .set_adr_i       (dec_rd_i),
        .clr_i           (wb_valid_i),
        .clr_adr_i       (wb_adr_i),
        .flush_clr_i     (flush_i && ex_valid_q && ex_q.rd_use),
        .flush_clr_adr_i (ex_q.rd),
        .q_rs1_adr_i     (dec_rs1_i),
        .q_rs2_adr_i     (dec_rs2_i),
        .q_rd_adr_i      (dec_rd_i),
        .pend_rs1_o      (pend_rs1),
        .pend_rs2_o      (pend_rs2),
        .pend_rd_o       (pend_rd),
        .busy_o          ()
    );

    always_comb begin
        hazard      = (dec_rs1_use_i && pend_rs1) || (dec_rs2_use_i && pend_rs2)
                   || (dec_rd_use_i && pend_rd);
        dec_ready_o = !hazard && !flush_i && (!ex_valid_q || ex_ready_i);
        accept      = dec_valid_i && dec_ready_o;
        op1         = operand(dec_rs1_use_i, dec_rs1_i, rf_data0_i);
        op2         = operand(dec_rs2_use_i, dec_rs2_i, rf_data1_i);
        ex_valid_d  = ex_valid_q;
        ex_d        = ex_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d  = 1'b1;
            ex_d.rs1    = op1;
            ex_d.rs2    = op2;
            ex_d.rd     = dec_rd_i;
            ex_d.rd_use = dec_rd_use_i;
            ex_d.imm    = dec_imm_i;
            ex_d.ctrl   = dec_ctrl_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_q       <= ex_d;
        end
    end

    assign rf_adr0_o     = dec_rs1_i;
    assign rf_adr1_o     = dec_rs2_i;
    assign ex_valid_o    = ex_valid_q;
    assign ex_rs1_data_o = ex_q.rs1;
    assign ex_rs2_data_o = ex_q.rs2;
    assign ex_rd_o       = ex_q.rd;
    assign ex_rd_use_o   = ex_q.rd_use;
    assign ex_imm_o      = ex_q.imm;
    assign ex_ctrl_o     = ex_q.ctrl;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios then random traffic, checked
// against an architectural model (busy set, register values, execute slot).
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        dec_valid_i, dec_ready_o;
    logic [5:0]  dec_rs1_i, dec_rs2_i, dec_rd_i;
    logic        dec_rs1_use_i, dec_rs2_use_i, dec_rd_use_i;
    logic [31:0] dec_imm_i;
    logic [15:0] dec_ctrl_i;
    logic [5:0]  rf_adr0_o, rf_adr1_o;
    logic [31:0] rf_data0_i, rf_data1_i;
    logic        wb_valid_i;
    logic [5:0]  wb_adr_i;
    logic [31:0] wb_data_i;
    logic        flush_i;
    logic        ex_valid_o, ex_ready_i;
    logic [31:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    logic [5:0]  ex_rd_o;
    logic        ex_rd_use_o;
    logic [15:0] ex_ctrl_o;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .reset_n(reset_n),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .dec_rs1_i(dec_rs1_i), .dec_rs1_use_i(dec_rs1_use_i),
        .dec_rs2_i(dec_rs2_i), .dec_rs2_use_i(dec_rs2_use_i),
        .dec_rd_i(dec_rd_i), .dec_rd_use_i(dec_rd_use_i),
        .dec_imm_i(dec_imm_i), .dec_ctrl_i(dec_ctrl_i),
        .rf_adr0_o(rf_adr0_o), .rf_data0_i(rf_data0_i),
        .rf_adr1_o(rf_adr1_o), .rf_data1_i(rf_data1_i),
        .wb_valid_i(wb_valid_i), .wb_adr_i(wb_adr_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
        .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
        .ex_rd_o(ex_rd_o), .ex_rd_use_o(ex_rd_use_o),
        .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o)
    );

    // ---------------- reference model ----------------
    localparam int PW = 119;
    logic [PW-1:0] exp_q[$];
    logic [31:0]   regs [32];
    logic [31:0]   m_busy;
    logic          m_ex_v;
    logic [5:0]    m_ex_rd;
    logic          m_ex_rd_use;
    int            n_checks = 0;
    int            n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic m_reset();
        m_busy = '0; m_ex_v = 1'b0; m_ex_rd = '0; m_ex_rd_use = 1'b0;
        exp_q.delete();
    endtask

    // A register is still outstanding unless it is being written back now.
    function automatic logic m_pend(input logic [5:0] r, input logic wv, input logic [5:0] wa);
        return (r != 0) && m_busy[r[4:0]] && !(wv && wa == r);
    endfunction

    // Architectural value of r as visible at the end of this cycle.
    function automatic logic [31:0] m_val(input logic u, input logic [5:0] r, input logic wv,
                                          input logic [5:0] wa, input logic [31:0] wd);
        if (!u || r == 0) return 32'h0;
        if (wv && wa == r) return wd;
        return regs[r[4:0]];
    endfunction

    // ---------------- driver ----------------
    task automatic cycle(input logic dv, input logic [5:0] rs1, input logic u1,
                         input logic [5:0] rs2, input logic u2, input logic [5:0] rd,
                         input logic ud, input logic [31:0] imm, input logic [15:0] ctrl,
                         input logic wv, input logic [5:0] wa, input logic [31:0] wd,
                         input logic fl, input logic er);
        logic exp_rdy;
        logic hz;
        dec_valid_i = dv; dec_rs1_i = rs1; dec_rs1_use_i = u1; dec_rs2_i = rs2;
        dec_rs2_use_i = u2; dec_rd_i = rd; dec_rd_use_i = ud; dec_imm_i = imm;
        dec_ctrl_i = ctrl; wb_valid_i = wv; wb_adr_i = wa; wb_data_i = wd;
        flush_i = fl; ex_ready_i = er;
        rf_data0_i = regs[rs1[4:0]];
        rf_data1_i = regs[rs2[4:0]];
        #1;
        hz = (u1 && m_pend(rs1, wv, wa)) || (u2 && m_pend(rs2, wv, wa)) || (ud && m_pend(rd, wv, wa));
        exp_rdy = !hz && !fl && (!m_ex_v || er);
        chk("dec_ready", dec_ready_o, exp_rdy);
        chk("rf_adr0", rf_adr0_o, rs1);
        chk("rf_adr1", rf_adr1_o, rs2);
        if (dv && exp_rdy)
            exp_q.push_back({m_val(u1, rs1, wv, wa, wd), m_val(u2, rs2, wv, wa, wd), rd, ud, imm, ctrl});
        if (wv && wa != 0) begin
            m_busy[wa[4:0]] = 1'b0;
            regs[wa[4:0]] = wd;
        end
        if (fl && m_ex_v && m_ex_rd_use) m_busy[m_ex_rd[4:0]] = 1'b0;
        if (dv && exp_rdy && ud && rd != 0) m_busy[rd[4:0]] = 1'b1;
        if (fl) m_ex_v = 1'b0;
        else if (dv && exp_rdy) begin
            m_ex_v = 1'b1; m_ex_rd = rd; m_ex_rd_use = ud;
        end else if (er) m_ex_v = 1'b0;
        @(posedge clk); #1;
        chk("ex_valid", ex_valid_o, m_ex_v);
        chk("busy", dut.u_scoreboard.busy_o, m_busy);
    endtask

    task automatic idle(input logic er);
        cycle(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 32'h0, 16'h0, 1'b0, 6'd0, 32'h0, 1'b0, er);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [PW-1:0] e;
        if (reset_n && ex_valid_o && (flush_i || ex_ready_i)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ex_unexpected: got rd %0d with no expected entry", ex_rd_o);
            end else begin
                e = exp_q.pop_front();
                if (!flush_i) begin
                    chk("ex_rs1_data", ex_rs1_data_o, e[118:87]);
                    chk("ex_rs2_data", ex_rs2_data_o, e[86:55]);
                    chk("ex_rd", ex_rd_o, e[54:49]);
                    chk("ex_rd_use", ex_rd_use_o, e[48]);
                    chk("ex_imm", ex_imm_o, e[47:16]);
                    chk("ex_ctrl", ex_ctrl_o, e[15:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] snap_imm;
        logic [5:0]  snap_rd;
        logic [5:0]  wa;
        logic        wv;
        logic [5:0]  busy_list[$];
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'h0 : $urandom;
        m_reset();
        reset_n = 1'b0;
        dec_valid_i = 0; dec_rs1_i = 0; dec_rs1_use_i = 0; dec_rs2_i = 0; dec_rs2_use_i = 0;
        dec_rd_i = 0; dec_rd_use_i = 0; dec_imm_i = 0; dec_ctrl_i = 0; rf_data0_i = 0;
        rf_data1_i = 0; wb_valid_i = 0; wb_adr_i = 0; wb_data_i = 0; flush_i = 0; ex_ready_i = 0;
        #12;
        chk("rst_ex_valid", ex_valid_o, 1'b0);
        chk("rst_ex_payload", {ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_use_o, ex_imm_o, ex_ctrl_o}, 0);
        chk("rst_dec_ready", dec_ready_o, 1'b1);
        chk("rst_busy", dut.u_scoreboard.busy_o, 32'h0);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // addi rd=5 from r0
        cycle(1, 6'd0, 1, 6'd0, 0, 6'd5, 1, 32'h11, 16'h1, 0, 6'd0, 0, 0, 1);
        chk("t1_ex_rd", ex_rd_o, 6'd5);
        chk("t1_ex_rs1", ex_rs1_data_o, 32'h0);
        chk("t1_busy5", dut.u_scoreboard.busy_o[5], 1'b1);
        // RAW stall on r5, released by a bypassed writeback
        repeat (3) cycle(1, 6'd5, 1, 6'd0, 0, 6'd6, 1, 32'h22, 16'h2, 0, 6'd0, 0, 0, 1);
        cycle(1, 6'd5, 1, 6'd0, 0, 6'd6, 1, 32'h22, 16'h2, 1, 6'd5, 32'hDEAD_BEEF, 0, 1);
        chk("t2_bypass", ex_rs1_data_o, 32'hDEAD_BEEF);
        // execute hold, then back-to-back replacement
        snap_imm = ex_imm_o; snap_rd = ex_rd_o;
        repeat (3) begin
            cycle(1, 6'd1, 1, 6'd0, 0, 6'd10, 1, 32'h33, 16'h3, 0, 6'd0, 0, 0, 0);
            chk("t3_hold_imm", ex_imm_o, snap_imm);
            chk("t3_hold_rd", ex_rd_o, snap_rd);
        end
        cycle(1, 6'd1, 1, 6'd0, 0, 6'd10, 1, 32'h44, 16'h4, 0, 6'd0, 0, 0, 1);
        chk("t3_no_bubble", ex_imm_o, 32'h44);
        // flush with rd=7 in execute
        cycle(1, 6'd2, 1, 6'd3, 1, 6'd7, 1, 32'h55, 16'h5, 0, 6'd0, 0, 0, 1);
        cycle(1, 6'd2, 1, 6'd0, 0, 6'd11, 1, 32'h66, 16'h6, 0, 6'd0, 0, 1, 0);
        chk("t4_busy7", dut.u_scoreboard.busy_o[7], 1'b0);
        // rd=0 never becomes busy
        cycle(1, 6'd0, 1, 6'd0, 0, 6'd0, 1, 32'h77, 16'h7, 0, 6'd0, 0, 0, 1);
        cycle(1, 6'd0, 1, 6'd0, 1, 6'd12, 1, 32'h88, 16'h8, 0, 6'd0, 0, 0, 1);
        chk("t5_busy0", dut.u_scoreboard.busy_o[0], 1'b0);
        // same-cycle writeback and re-set of r9
        cycle(1, 6'd0, 0, 6'd0, 0, 6'd9, 1, 32'h99, 16'h9, 0, 6'd0, 0, 0, 1);
        cycle(1, 6'd0, 0, 6'd0, 0, 6'd9, 1, 32'haa, 16'ha, 1, 6'd9, 32'h1234, 0, 1);
        chk("t6_busy9", dut.u_scoreboard.busy_o[9], 1'b1);
        // asynchronous reset in the middle of a stall on r9
        dec_valid_i = 1; dec_rs1_i = 6'd9; dec_rs1_use_i = 1; dec_rd_use_i = 0;
        wb_valid_i = 0; flush_i = 0; ex_ready_i = 0;
        #1;
        chk("t6_stall", dec_ready_o, 1'b0);
        #1 reset_n = 1'b0;
        dec_valid_i = 0;
        #1;
        chk("t6_rst_ex_valid", ex_valid_o, 1'b0);
        chk("t6_rst_payload", {ex_rs1_data_o, ex_rs2_data_o, ex_rd_o, ex_rd_use_o, ex_imm_o, ex_ctrl_o}, 0);
        chk("t6_rst_busy", dut.u_scoreboard.busy_o, 32'h0);
        m_reset();
        @(negedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            busy_list.delete();
            for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(6'(r));
            wv = 1'b0; wa = 6'd0;
            if (busy_list.size() > 0 && $urandom_range(0, 9) < 6) begin
                wv = 1'b1; wa = busy_list[$urandom_range(0, busy_list.size() - 1)];
            end else if ($urandom_range(0, 9) == 0) begin
                wv = 1'b1; wa = 6'($urandom_range(0, 7));
            end
            cycle($urandom_range(0, 3) != 0, 6'($urandom_range(0, 7)), 1'($urandom),
                  6'($urandom_range(0, 7)), 1'($urandom), 6'($urandom_range(0, 7)), 1'($urandom),
                  $urandom, 16'($urandom), wv, wa, $urandom,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (3) idle(1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
